aes_inv_cipher_seq: RTL
=======================

AES_INV_CIPHER_SEQ -- requirements
Module: aes_inv_cipher_seq

Interface
REQ-001 Parameters: none; key size is selected per operation by the bits input.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request decryption of data_in; sampled only while idle.
REQ-005 bits  in  2  key size: 00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=reserved.
REQ-006 data_in  in  128  ciphertext; [127:120]=byte 0 (FIPS-197 column-major order).
REQ-007 rk_addr  out  4  round-key index presented to the external round-key RAM.
REQ-008 rk_en  out  1  round-key read enable.
REQ-009 rk_data  in  128  round key K[rk_addr]; registered-output RAM, valid the cycle after rk_addr/rk_en were presented.
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-cycle pulse; data_out valid from this cycle.
REQ-012 data_out  out  128  plaintext; same byte order as data_in.

Function
REQ-013 FSM states: IDLE, FETCH, ADD0, ROUND, FINAL.
REQ-014 IDLE: start=1 with bits!=11 -> latch data_in into state register, latch Nr, rk_addr<=Nr, rk_en<=1, busy<=1, go to FETCH.
REQ-015 IDLE: start=1 with bits=11 -> ignored; no state change, busy stays 0.
REQ-016 FETCH (1 cycle): rk_addr<=Nr-1; go to ADD0.
REQ-017 ADD0 (1 cycle): state<=state^rk_data (K[Nr]); rk_addr<=Nr-2; round counter r<=Nr-1; go to ROUND.
REQ-018 ROUND: state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^rk_data), rk_data being K[r]; r<=r-1; rk_addr decrements, saturating at 0; when r=1, go to FINAL.
REQ-019 FINAL: data_out<=InvSubBytes(InvShiftRows(state))^rk_data (K[0]); done<=1 for one cycle; busy<=0; rk_en<=0; go to IDLE.
REQ-020 Latency: done is high in the cycle following the (Nr+2)th rising edge after the edge that accepted start: 12, 14 and 16 cycles for 128, 192 and 256.
REQ-021 start while busy is ignored; latched data and Nr are unaffected.
REQ-022 A start present in the done cycle is accepted (back-to-back operation, no bubble).
REQ-023 data_out holds its value until the next FINAL; it does not change during an operation.
REQ-024 InvSubBytes is the FIPS-197 inverse S-box, applied per byte and combinationally within the round.
REQ-025 InvMixColumns uses GF(2^8) with polynomial 0x11B and coefficients {0e,0b,0d,09}.
REQ-026 rk_addr never exceeds 14 and never underflows below 0.
REQ-027 bits changes during an operation have no effect; Nr is latched at start.

Reset
REQ-028 On rst=1, immediately and independent of clk: FSM=IDLE, busy=0, done=0, rk_en=0, rk_addr=0, data_out=0, state register=0, r=0.
REQ-029 rst asserted mid-operation aborts it: no done pulse, data_out=0; the first start after release begins a fresh operation.

Verification
REQ-030 AES-128: RAM preloaded with the expansion of key 000102030405060708090a0b0c0d0e0f (K[10]=13111d7fe3944a17f307a78b4d2b30c5), bits=00, data_in=69c4e0d86a7b0430d8cdb78070b4c55a -> done after 12 cycles, data_out=00112233445566778899aabbccddeeff.
REQ-031 AES-192: key 000102...1617 expanded, bits=01, data_in=dda97ca4864cdfe06eaf70a0ec0d7191 -> done after 14 cycles, data_out=00112233445566778899aabbccddeeff.
REQ-032 AES-256: key 000102...1e1f expanded, bits=10, data_in=8ea2b7ca516745bfeafc49904b496089 -> done after 16 cycles, data_out=00112233445566778899aabbccddeeff; rk_addr sequence 14,13,...,0.
REQ-033 Second start with different data_in pulsed at cycle 5 of an AES-128 operation -> ignored; first result correct, exactly one done; a start in the done cycle starts the next operation immediately.
REQ-034 rst pulsed at cycle 6 of an AES-256 operation -> busy=0 and data_out=0 immediately, no done; a subsequent AES-128 run gives the REQ-030 result.
REQ-035 bits=11 with start=1 -> busy stays 0, rk_en stays 0, no done pulse within 20 cycles.

Source files
------------

// File: rtl/aes_inv_cipher_seq.sv
// aes_inv_cipher_seq
// Iterative AES inverse cipher for 128/192/256-bit keys. One decryption round
// is performed per clock. Round keys come from an external registered-output
// RAM, read in descending order K[Nr] .. K[0].
//
// Ports:
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous active-high reset
//   start     in   1    begin decrypting data_in (sampled only while idle)
//   bits      in   2    key size: 00=128, 01=192, 10=256, 11=reserved (ignored)
//   data_in   in   128  ciphertext, [127:120] is byte 0
//   rk_addr   out  4    round-key RAM address
//   rk_en     out  1    round-key RAM read enable
//   rk_data   in   128  round key, valid the cycle after rk_addr/rk_en
//   busy      out  1    operation in progress
//   done      out  1    one-cycle pulse, data_out valid from this cycle
//   data_out  out  128  plaintext, held until the next operation completes
module aes_inv_cipher_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   bits,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_addr,
  output logic         rk_en,
  input  logic [127:0] rk_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  typedef enum logic [2:0] {IDLE, FETCH, ADD0, ROUND, FINAL} fsm_t;

  localparam logic [0:255][7:0] ISBOX = {
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  fsm_t         fsm, fsm_nxt;
  logic [127:0] st;
  logic [3:0]   nr;
  logic [3:0]   r;
  logic [3:0]   nr_sel;
  logic         accept;
  logic [127:0] final_out;
  logic [127:0] round_out;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; only 09/0b/0d/0e are used.
  function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  // Byte (row rr, column c) sits at index rr + 4*c; row rr rotates right by rr.
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        o[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c-rr)&3)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = ISBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mulc(a0,4'he) ^ mulc(a1,4'hb) ^ mulc(a2,4'hd) ^ mulc(a3,4'h9);
      o[119-32*c -: 8] = mulc(a0,4'h9) ^ mulc(a1,4'he) ^ mulc(a2,4'hb) ^ mulc(a3,4'hd);
      o[111-32*c -: 8] = mulc(a0,4'hd) ^ mulc(a1,4'h9) ^ mulc(a2,4'he) ^ mulc(a3,4'hb);
      o[103-32*c -: 8] = mulc(a0,4'hb) ^ mulc(a1,4'hd) ^ mulc(a2,4'h9) ^ mulc(a3,4'he);
    end
    return o;
  endfunction

  // The final round is the regular round without InvMixColumns, so both share
  // the substitution and key-add path.
  assign final_out = inv_sub(inv_shift(st)) ^ rk_data;
  assign round_out = inv_mix(final_out);
  assign accept    = (fsm == IDLE) && start && (bits != 2'b11);

  always_comb begin
    nr_sel = 4'd10;
    case (bits)
      2'b01:   nr_sel = 4'd12;
      2'b10:   nr_sel = 4'd14;
      default: nr_sel = 4'd10;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_nxt = FETCH;
      FETCH:   fsm_nxt = ADD0;
      ADD0:    fsm_nxt = ROUND;
      ROUND:   if (r == 4'd1) fsm_nxt = FINAL;
      FINAL:   fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // The RAM has one cycle of read latency, so rk_addr always runs one key
  // ahead of the key being consumed: FETCH exists only to cover that latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= '0;
      nr       <= '0;
      r        <= '0;
      rk_addr  <= '0;
      rk_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (accept) begin
            st      <= data_in;
            nr      <= nr_sel;
            rk_addr <= nr_sel;
            rk_en   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: rk_addr <= nr - 4'd1;
        ADD0: begin
          st      <= st ^ rk_data;
          rk_addr <= nr - 4'd2;
          r       <= nr - 4'd1;
        end
        ROUND: begin
          st <= round_out;
          r  <= r - 4'd1;
          if (rk_addr != 4'd0) rk_addr <= rk_addr - 4'd1;
        end
        FINAL: begin
          data_out <= final_out;
          done     <= 1'b1;
          busy     <= 1'b0;
          rk_en    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
